// File: rtl/i2c_slave_reg8_dat8.sv
// I2C responder: 7-bit device address, 8-bit register pointer, 8-bit data, byte-wide register/ROM port.
// SCL/SDA are oversampled on clk; SDA is driven 3 clk after SCL falls. No clock stretching.
module i2c_slave_reg8_dat8 #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         WRITE_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_sclk,
  input  logic       i2c_sdat_IN,
  output logic       i2c_sdat_OUT,
  output logic       i2c_sdat_OE,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, DEVADDR, ACK_DEV, REGADDR, ACK_REG, WDATA, ACK_W, RDATA, MACK, WAIT
  } state_t;

  // [0],[1] synchronizer, [2] history; reset high so release of reset never looks like START
  logic [2:0] scl_sync, sda_sync;
  logic       scl_s, scl_d, sda_s, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], i2c_sclk};
      sda_sync <= {sda_sync[1:0], i2c_sdat_IN};
    end
  end

  assign scl_s     = scl_sync[1];
  assign scl_d     = scl_sync[2];
  assign sda_s     = sda_sync[1];
  assign sda_d     = sda_sync[2];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  state_t     state, state_nxt;
  logic [7:0] shift, shift_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       pend, pend_nxt;
  logic       rw, rw_nxt;
  logic       oe, oe_nxt;
  logic       busy_nxt;
  logic [7:0] addr_nxt, wdata_nxt;
  logic       we_nxt;
  logic [7:0] byte_in;

  assign byte_in = {shift[6:0], sda_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= 8'h00;
      cnt       <= 3'd0;
      pend      <= 1'b0;
      rw        <= 1'b0;
      oe        <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= 8'h00;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift     <= shift_nxt;
      cnt       <= cnt_nxt;
      pend      <= pend_nxt;
      rw        <= rw_nxt;
      oe        <= oe_nxt;
      busy      <= busy_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_we    <= we_nxt;
    end
  end

  // pend marks "8 bits taken, acknowledge on the next SCL fall"
  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    rw_nxt    = rw;
    oe_nxt    = oe;
    busy_nxt  = busy;
    addr_nxt  = mem_we ? mem_addr + 8'd1 : mem_addr;
    wdata_nxt = mem_wdata;
    we_nxt    = 1'b0;

    if (start_det) begin
      state_nxt = DEVADDR;
      cnt_nxt   = 3'd0;
      pend_nxt  = 1'b0;
      oe_nxt    = 1'b0;
    end else if (stop_det) begin
      state_nxt = IDLE;
      pend_nxt  = 1'b0;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        DEVADDR: begin
          if (scl_rise && !pend) begin
            shift_nxt = byte_in;
            cnt_nxt   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (byte_in[7:1] == DEV_ADDR) begin
                busy_nxt = 1'b1;
                rw_nxt   = byte_in[0];
                pend_nxt = 1'b1;
              end else begin
                state_nxt = WAIT;
                oe_nxt    = 1'b0;
              end
            end
          end else if (scl_fall && pend) begin
            pend_nxt  = 1'b0;
            oe_nxt    = 1'b1;
            state_nxt = ACK_DEV;
          end
        end
        ACK_DEV: begin
          if (scl_fall) begin
            cnt_nxt = 3'd0;
            if (rw) begin
              shift_nxt = mem_rdata;
              oe_nxt    = ~mem_rdata[7];
              state_nxt = RDATA;
            end else begin
              oe_nxt    = 1'b0;
              state_nxt = REGADDR;
            end
          end
        end
        REGADDR: begin
          if (scl_rise && !pend) begin
            shift_nxt = byte_in;
            cnt_nxt   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              addr_nxt = byte_in;
              pend_nxt = 1'b1;
            end
          end else if (scl_fall && pend) begin
            pend_nxt  = 1'b0;
            oe_nxt    = 1'b1;
            state_nxt = ACK_REG;
          end
        end
        ACK_REG, ACK_W: begin
          if (scl_fall) begin
            cnt_nxt   = 3'd0;
            oe_nxt    = 1'b0;
            state_nxt = WDATA;
          end
        end
        WDATA: begin
          if (scl_rise && !pend) begin
            shift_nxt = byte_in;
            cnt_nxt   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (WRITE_EN != 0) begin
                wdata_nxt = byte_in;
                we_nxt    = 1'b1;
                pend_nxt  = 1'b1;
              end else begin
                state_nxt = WAIT;
              end
            end
          end else if (scl_fall && pend) begin
            pend_nxt  = 1'b0;
            oe_nxt    = 1'b1;
            state_nxt = ACK_W;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (cnt == 3'd7) begin
              cnt_nxt   = 3'd0;
              oe_nxt    = 1'b0;
              state_nxt = MACK;
            end else begin
              shift_nxt = {shift[6:0], 1'b0};
              oe_nxt    = ~shift[6];
              cnt_nxt   = cnt + 3'd1;
            end
          end
        end
        MACK: begin
          // Pointer advances at the ACK rise so mem_rdata has half an SCL period to settle
          if (scl_rise && !pend) begin
            if (!sda_s) begin
              addr_nxt = mem_addr + 8'd1;
              pend_nxt = 1'b1;
            end else begin
              state_nxt = WAIT;
            end
          end else if (scl_fall && pend) begin
            pend_nxt  = 1'b0;
            cnt_nxt   = 3'd0;
            shift_nxt = mem_rdata;
            oe_nxt    = ~mem_rdata[7];
            state_nxt = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign i2c_sdat_OE  = oe;
  assign i2c_sdat_OUT = 1'b0;

endmodule

// File: tb/tb_i2c_slave_reg8_dat8.sv
// Directed bench: bit-level I2C master on a wired-AND bus with two responders (0x50 writable, 0x52 read-only).
module tb_i2c_slave_reg8_dat8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       sda_bus;
  logic       out0, oe0, we0, busy0;
  logic       out1, oe1, we1, busy1;
  logic [7:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;
  logic [7:0] mem0 [256];

  int         n_pass = 0, n_total = 0;
  int         we_cnt0 = 0, we_cnt1 = 0;
  logic       oe_seen0 = 1'b0, busy_seen0 = 1'b0;
  logic [7:0] st_addr[$], st_data[$];

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~oe0 & ~oe1;
  assign rdata0  = mem0[addr0];
  assign rdata1  = addr1 ^ 8'hFF;

  i2c_slave_reg8_dat8 #(.DEV_ADDR(7'h50), .WRITE_EN(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .i2c_sclk(scl_m), .i2c_sdat_IN(sda_bus),
    .i2c_sdat_OUT(out0), .i2c_sdat_OE(oe0), .mem_addr(addr0), .mem_rdata(rdata0),
    .mem_wdata(wdata0), .mem_we(we0), .busy(busy0));

  i2c_slave_reg8_dat8 #(.DEV_ADDR(7'h52), .WRITE_EN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .i2c_sclk(scl_m), .i2c_sdat_IN(sda_bus),
    .i2c_sdat_OUT(out1), .i2c_sdat_OE(oe1), .mem_addr(addr1), .mem_rdata(rdata1),
    .mem_wdata(wdata1), .mem_we(we1), .busy(busy1));

  always @(negedge clk) begin
    if (we0) begin
      we_cnt0++;
      st_addr.push_back(addr0);
      st_data.push_back(wdata0);
      mem0[addr0] = wdata0;
    end
    if (we1) we_cnt1++;
    if (oe0) oe_seen0 = 1'b1;
    if (busy0) busy_seen0 = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic quarter();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic start_cond();
    sda_m = 1'b1; quarter();
    scl_m = 1'b1; quarter();
    sda_m = 1'b0; quarter();
    scl_m = 1'b0; quarter();
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; quarter();
    scl_m = 1'b1; quarter();
    sda_m = 1'b1; quarter();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; quarter();
    scl_m = 1'b1; quarter();
    quarter();
    scl_m = 1'b0; quarter();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; quarter();
    scl_m = 1'b1; quarter();
    b = sda_bus; quarter();
    scl_m = 1'b0; quarter();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(r);
    ack = ~r;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      read_bit(r);
      b[i] = r;
    end
    write_bit(~ack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         base;

    for (int i = 0; i < 256; i++) mem0[i] = i[7:0] ^ 8'hFF;

    repeat (3) @(posedge clk);
    #1;
    check("rst_oe", oe0, 1'b0);
    check("rst_out", out0, 1'b0);
    check("rst_addr", addr0, 8'h00);
    check("rst_wdata", wdata0, 8'h00);
    check("rst_we", we0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    rst_n = 1'b1;
    quarter();

    // random read of 0x10 and 0x11
    start_cond();
    write_byte(8'hA0, ack); check("rd_ack_dev", ack, 1'b1);
    write_byte(8'h10, ack); check("rd_ack_reg", ack, 1'b1);
    start_cond();
    write_byte(8'hA1, ack); check("rd_ack_devr", ack, 1'b1);
    read_byte(d, 1'b1);     check("rd_byte0", d, 8'hEF);
    check("rd_busy", busy0, 1'b1);
    read_byte(d, 1'b0);     check("rd_byte1", d, 8'hEE);
    check("rd_release", oe0, 1'b0);
    stop_cond();
    check("rd_busy_stop", busy0, 1'b0);
    check("rd_addr_end", addr0, 8'h11);

    // single write 0x5A to 0x10
    base = we_cnt0; st_addr.delete(); st_data.delete();
    start_cond();
    write_byte(8'hA0, ack); check("wr_ack_dev", ack, 1'b1);
    write_byte(8'h10, ack); check("wr_ack_reg", ack, 1'b1);
    write_byte(8'h5A, ack); check("wr_ack_dat", ack, 1'b1);
    stop_cond();
    check("wr_we_cnt", we_cnt0 - base, 1);
    check("wr_addr", st_addr[0], 8'h10);
    check("wr_data", st_data[0], 8'h5A);
    check("wr_addr_inc", addr0, 8'h11);
    check("wr_busy", busy0, 1'b0);

    // wrong device address is ignored
    base = we_cnt0; oe_seen0 = 1'b0; busy_seen0 = 1'b0;
    start_cond();
    write_byte(8'hA2, ack); check("wa_nack", ack, 1'b0);
    write_byte(8'h10, ack);
    write_byte(8'h33, ack);
    stop_cond();
    check("wa_oe_seen", oe_seen0, 1'b0);
    check("wa_busy_seen", busy_seen0, 1'b0);
    check("wa_we_cnt", we_cnt0 - base, 0);
    st_addr.delete(); st_data.delete();
    start_cond();
    write_byte(8'hA0, ack);
    write_byte(8'h20, ack);
    write_byte(8'h44, ack); check("wa_next_ack", ack, 1'b1);
    stop_cond();
    check("wa_next_addr", st_addr[0], 8'h20);
    check("wa_next_data", st_data[0], 8'h44);

    // pointer wrap
    st_addr.delete(); st_data.delete();
    start_cond();
    write_byte(8'hA0, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    stop_cond();
    check("wrap_cnt", st_addr.size(), 2);
    check("wrap_addr0", st_addr[0], 8'hFF);
    check("wrap_data0", st_data[0], 8'h11);
    check("wrap_addr1", st_addr[1], 8'h00);
    check("wrap_data1", st_data[1], 8'h22);
    check("wrap_addr_end", addr0, 8'h01);

    // STOP in the middle of the register byte, then a clean write
    st_addr.delete(); st_data.delete();
    start_cond();
    write_byte(8'hA0, ack);
    write_bit(1'b0); write_bit(1'b0); write_bit(1'b0); write_bit(1'b1);
    stop_cond();
    check("abort_busy", busy0, 1'b0);
    start_cond();
    write_byte(8'hA0, ack);
    write_byte(8'h05, ack);
    write_byte(8'h77, ack); check("abort_ack", ack, 1'b1);
    stop_cond();
    check("abort_cnt", st_addr.size(), 1);
    check("abort_addr", st_addr[0], 8'h05);
    check("abort_data", st_data[0], 8'h77);

    // read-only responder: data byte NACKed, reads still work
    base = we_cnt1;
    start_cond();
    write_byte(8'hA4, ack); check("ro_ack_dev", ack, 1'b1);
    write_byte(8'h10, ack); check("ro_ack_reg", ack, 1'b1);
    write_byte(8'h33, ack); check("ro_nack_dat", ack, 1'b0);
    stop_cond();
    check("ro_we_cnt", we_cnt1 - base, 0);
    start_cond();
    write_byte(8'hA4, ack);
    write_byte(8'h10, ack);
    start_cond();
    write_byte(8'hA5, ack); check("ro_ack_devr", ack, 1'b1);
    read_byte(d, 1'b0);     check("ro_rdata", d, 8'hEF);
    stop_cond();

    // reset while the responder drives a 0 (0x90 holds 0x6F)
    start_cond();
    write_byte(8'hA0, ack);
    write_byte(8'h90, ack);
    start_cond();
    write_byte(8'hA1, ack);
    check("rst_mid_oe_before", oe0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_oe_async", oe0, 1'b0);
    scl_m = 1'b1; sda_m = 1'b1;
    quarter();
    check("rst_mid_busy", busy0, 1'b0);
    check("rst_mid_addr", addr0, 8'h00);
    rst_n = 1'b1;
    quarter();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
